// File: rtl/scale_addr_gen_if.sv
// Pixel/config bus between the video timing generator and scale_addr_gen.
// The timing side (master) drives counts and config; the address generator (slave) returns the mapped address.
interface scale_addr_gen_if #(
    parameter int H_BITS = 11,
    parameter int V_BITS = 10,
    parameter int ADDR_W = 17
);
    logic [1:0]        h_shift_in;
    logic [1:0]        v_shift_in;
    logic              cfg_valid_in;
    logic              px_valid_in;
    logic [H_BITS-1:0] hcount_in;
    logic [V_BITS-1:0] vcount_in;
    logic [H_BITS-1:0] scaled_hcount_out;
    logic [V_BITS-1:0] scaled_vcount_out;
    logic [ADDR_W-1:0] addr_out;
    logic              valid_addr_out;
    logic              px_valid_out;
    logic              cfg_pending_out;

    modport master (
        output h_shift_in, v_shift_in, cfg_valid_in, px_valid_in, hcount_in, vcount_in,
        input  scaled_hcount_out, scaled_vcount_out, addr_out, valid_addr_out,
               px_valid_out, cfg_pending_out
    );

    modport slave (
        input  h_shift_in, v_shift_in, cfg_valid_in, px_valid_in, hcount_in, vcount_in,
        output scaled_hcount_out, scaled_vcount_out, addr_out, valid_addr_out,
               px_valid_out, cfg_pending_out
    );
endinterface

// File: rtl/scale_addr_gen.sv
// scale_addr_gen: 3-stage pipeline mapping raw video counts onto a linear framebuffer read address.
// Build macro SCALE_CENTER_EN centres the scaled image in the display; undefined anchors it top-left.
module scale_addr_gen #(
    parameter int H_BITS   = 11,
    parameter int V_BITS   = 10,
    parameter int SRC_W    = 240,
    parameter int SRC_H    = 320,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int ADDR_W   = 17
) (
    input  logic            clk_in,
    input  logic            rst_in,
    scale_addr_gen_if.slave bus
);
    localparam logic [H_BITS-1:0] SRC_W_H = H_BITS'(SRC_W);
    localparam logic [V_BITS-1:0] SRC_H_V = V_BITS'(SRC_H);
    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

`ifdef SCALE_CENTER_EN
    function automatic int center_off(input int active, input int src, input logic [1:0] sh);
        int span;
        span = src << sh;
        return (span >= active) ? 32'sd0 : ((active - span) >> 1);
    endfunction

    localparam logic [H_BITS-1:0] H_OFF_RST = H_BITS'(center_off(H_ACTIVE, SRC_W, 2'd0));
    localparam logic [V_BITS-1:0] V_OFF_RST = V_BITS'(center_off(V_ACTIVE, SRC_H, 2'd0));

    logic [H_BITS-1:0] h_off_q;
    logic [V_BITS-1:0] v_off_q;
`endif

    logic              frame_start_s, apply_s;
    logic [1:0]        h_act_q, h_act_d, v_act_q, v_act_d;
    logic [1:0]        h_pend_q, h_pend_d, v_pend_q, v_pend_d;
    logic              pending_q, pending_d;
    logic [H_BITS-1:0] h_off_s;
    logic [V_BITS-1:0] v_off_s;

    logic [H_BITS-1:0] s1_col_q, s1_col_d, s2_col_q, s2_col_d, s3_col_q, s3_col_d;
    logic [V_BITS-1:0] s1_row_q, s1_row_d, s2_row_q, s2_row_d, s3_row_q, s3_row_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic              s1_below_q, s1_below_d, s2_inb_q, s2_inb_d, s3_vaddr_q, s3_vaddr_d;
    logic [ADDR_W-1:0] s2_base_q, s2_base_d, s3_addr_q, s3_addr_d;

    // Config double-buffering plus the three pipeline stages; the frame-start pixel sees the applied config.
    always_comb begin
        frame_start_s = bus.px_valid_in && (bus.hcount_in == {H_BITS{1'b0}})
                        && (bus.vcount_in == {V_BITS{1'b0}});
        apply_s       = frame_start_s && pending_q;
        h_act_d       = apply_s ? h_pend_q : h_act_q;
        v_act_d       = apply_s ? v_pend_q : v_act_q;
        h_pend_d      = bus.cfg_valid_in ? bus.h_shift_in : h_pend_q;
        v_pend_d      = bus.cfg_valid_in ? bus.v_shift_in : v_pend_q;
        pending_d     = bus.cfg_valid_in ? 1'b1 : (apply_s ? 1'b0 : pending_q);
`ifdef SCALE_CENTER_EN
        h_off_s    = apply_s ? H_BITS'(center_off(H_ACTIVE, SRC_W, h_pend_q)) : h_off_q;
        v_off_s    = apply_s ? V_BITS'(center_off(V_ACTIVE, SRC_H, v_pend_q)) : v_off_q;
        s1_below_d = (bus.hcount_in < h_off_s) || (bus.vcount_in < v_off_s);
`else
        h_off_s    = {H_BITS{1'b0}};
        v_off_s    = {V_BITS{1'b0}};
        s1_below_d = 1'b0;
`endif
        s1_col_d   = (bus.hcount_in - h_off_s) >> h_act_d;
        s1_row_d   = (bus.vcount_in - v_off_s) >> v_act_d;
        s1_valid_d = bus.px_valid_in;

        s2_col_d   = s1_col_q;
        s2_row_d   = s1_row_q;
        s2_valid_d = s1_valid_q;
        s2_inb_d   = s1_valid_q && !s1_below_q && (s1_col_q < SRC_W_H) && (s1_row_q < SRC_H_V);
        s2_base_d  = ADDR_W'(s1_row_q) * SRC_W_A;

        s3_col_d   = s2_col_q;
        s3_row_d   = s2_row_q;
        s3_valid_d = s2_valid_q;
        s3_vaddr_d = s2_inb_q;
        s3_addr_d  = s2_inb_q ? (s2_base_q + ADDR_W'(s2_col_q)) : {ADDR_W{1'b0}};
    end

    // State and pipeline registers; reset flushes the pipe and reverts to unscaled mapping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_act_q    <= 2'd0;
            v_act_q    <= 2'd0;
            h_pend_q   <= 2'd0;
            v_pend_q   <= 2'd0;
            pending_q  <= 1'b0;
            s1_col_q   <= {H_BITS{1'b0}};
            s1_row_q   <= {V_BITS{1'b0}};
            s1_valid_q <= 1'b0;
            s1_below_q <= 1'b0;
            s2_col_q   <= {H_BITS{1'b0}};
            s2_row_q   <= {V_BITS{1'b0}};
            s2_valid_q <= 1'b0;
            s2_inb_q   <= 1'b0;
            s2_base_q  <= {ADDR_W{1'b0}};
            s3_col_q   <= {H_BITS{1'b0}};
            s3_row_q   <= {V_BITS{1'b0}};
            s3_valid_q <= 1'b0;
            s3_vaddr_q <= 1'b0;
            s3_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            h_act_q    <= h_act_d;
            v_act_q    <= v_act_d;
            h_pend_q   <= h_pend_d;
            v_pend_q   <= v_pend_d;
            pending_q  <= pending_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_valid_q <= s1_valid_d;
            s1_below_q <= s1_below_d;
            s2_col_q   <= s2_col_d;
            s2_row_q   <= s2_row_d;
            s2_valid_q <= s2_valid_d;
            s2_inb_q   <= s2_inb_d;
            s2_base_q  <= s2_base_d;
            s3_col_q   <= s3_col_d;
            s3_row_q   <= s3_row_d;
            s3_valid_q <= s3_valid_d;
            s3_vaddr_q <= s3_vaddr_d;
            s3_addr_q  <= s3_addr_d;
        end
    end

`ifdef SCALE_CENTER_EN
    // Centring offsets follow the active shifts; reset values match the unscaled mapping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_off_q <= H_OFF_RST;
            v_off_q <= V_OFF_RST;
        end else begin
            h_off_q <= h_off_s;
            v_off_q <= v_off_s;
        end
    end
`endif

    assign bus.scaled_hcount_out = s3_col_q;
    assign bus.scaled_vcount_out = s3_row_q;
    assign bus.addr_out          = s3_addr_q;
    assign bus.valid_addr_out    = s3_vaddr_q;
    assign bus.px_valid_out      = s3_valid_q;
    assign bus.cfg_pending_out   = pending_q;
endmodule
